alu_seq: RTL and testbench

Parametrised multi-cycle ALU for the RISC datapath. It adds a valid/ready handshake, registered results, and iterative multiply and divide/remainder units to the basic integer operation set. It sits in the execute stage; single-cycle ops complete in one clock, and iterative ops stall issue through `InReady`.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake/operand bus for alu_seq: requester drives operands and opcode,
// the ALU returns ready, the registered result and its status flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUControl;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] ALUOut;
  logic             Zero;
  logic             OutValid;
  logic             DivByZero;

  modport master (
    output A, B, ALUControl, InValid,
    input  InReady, ALUOut, Zero, OutValid, DivByZero
  );

  modport slave (
    input  A, B, ALUControl, InValid,
    output InReady, ALUOut, Zero, OutValid, DivByZero
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute-stage ALU with a valid/ready handshake.
// Single-cycle ops register their result at the accept edge; mul (and
// divu/remu when ALU_DIV_EN is defined) iterate one bit per clock for
// WIDTH cycles while InReady is held low.
// Optional feature macro: ALU_DIV_EN (restoring divider for 1011/1100).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL  = 4'b1010;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;
`endif

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  // Iteration working registers: acc = product / partial remainder,
  // opa = multiplier / quotient-in-progress, opb = multiplicand / divisor.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] res;
  logic             fin;

`ifdef ALU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             is_rem_q, is_rem_d;
  logic             dbz_q, dbz_d;
  logic             res_dbz;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
`endif

  // Combinational result of every single-cycle opcode; undefined -> 0.
  function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = ~(a | b);
      4'b0101: r = a ^ b;
      4'b0110: r = a << sh;
      4'b0111: r = a >> sh;
      4'b1000: r = (a < b) ? WIDTH'(1) : '0;
      4'b1001: r = (sa < sb) ? WIDTH'(1) : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Next-state, iteration step and result selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res         = '0;
    fin         = 1'b0;

    mul_acc = acc_q + (opa_q[0] ? opb_q : '0);

`ifdef ALU_DIV_EN
    is_div_d = is_div_q;
    is_rem_d = is_rem_q;
    dbz_d    = dbz_q;
    res_dbz  = 1'b0;
    // Restoring step: shift next dividend bit in, subtract if it fits.
    r_shift  = {acc_q, opa_q[WIDTH-1]};
    diff     = r_shift - {1'b0, opb_q};
    if (!diff[WIDTH]) begin
      div_rem = diff[WIDTH-1:0];
      div_quo = {opa_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem = r_shift[WIDTH-1:0];
      div_quo = {opa_q[WIDTH-2:0], 1'b0};
    end
`endif

    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
          if (bus.ALUControl == OP_MUL) begin
            acc_d   = '0;
            opa_d   = bus.B;
            opb_d   = bus.A;
            cnt_d   = CW'(WIDTH);
            state_d = ITER;
`ifdef ALU_DIV_EN
            is_div_d = 1'b0;
            is_rem_d = 1'b0;
          end else if ((bus.ALUControl == OP_DIVU || bus.ALUControl == OP_REMU)
                       && bus.B != '0) begin
            acc_d    = '0;
            opa_d    = bus.A;
            opb_d    = bus.B;
            cnt_d    = CW'(WIDTH);
            is_div_d = 1'b1;
            is_rem_d = (bus.ALUControl == OP_REMU);
            state_d  = ITER;
          end else if (bus.ALUControl == OP_DIVU) begin
            res     = '1;
            res_dbz = 1'b1;
            fin     = 1'b1;
          end else if (bus.ALUControl == OP_REMU) begin
            res     = bus.A;
            res_dbz = 1'b1;
            fin     = 1'b1;
`endif
          end else begin
            res = single_op(bus.ALUControl, bus.A, bus.B);
            fin = 1'b1;
          end
        end
      end
      ITER: begin
        cnt_d = cnt_q - CW'(1);
`ifdef ALU_DIV_EN
        if (is_div_q) begin
          acc_d = div_rem;
          opa_d = div_quo;
          res   = is_rem_q ? div_rem : div_quo;
        end else begin
          acc_d = mul_acc;
          opa_d = opa_q >> 1;
          opb_d = opb_q << 1;
          res   = mul_acc;
        end
`else
        acc_d = mul_acc;
        opa_d = opa_q >> 1;
        opb_d = opb_q << 1;
        res   = mul_acc;
`endif
        if (cnt_q == CW'(1)) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      alu_out_d   = res;
      zero_d      = (res == '0);
      out_valid_d = 1'b1;
`ifdef ALU_DIV_EN
      dbz_d       = res_dbz;
`endif
    end
  end

  // FSM, counter and registered outputs; reset aborts any iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_out_q   <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_DIV_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_DIV_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  // Iteration datapath; always loaded before use, so no reset needed.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    opa_q <= opa_d;
    opb_q <= opb_d;
`ifdef ALU_DIV_EN
    is_div_q <= is_div_d;
    is_rem_q <= is_rem_d;
`endif
  end

  assign bus.InReady  = (state_q == IDLE);
  assign bus.ALUOut   = alu_out_q;
  assign bus.Zero     = zero_q;
  assign bus.OutValid = out_valid_q;
`ifdef ALU_DIV_EN
  assign bus.DivByZero = dbz_q;
`else
  assign bus.DivByZero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32); divider checks follow ALU_DIV_EN.
module tb_alu_seq;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.ALUControl = op;
    bus.A          = a;
    bus.B          = b;
    bus.InValid    = 1'b1;
  endtask

  // Drive one single-cycle op and check its result on the next negedge.
  task automatic single(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
    @(negedge clk);
    drive(op, a, b);
    @(negedge clk);
    bus.InValid = 1'b0;
    chk({tag, "_vld"}, 64'(bus.OutValid), 64'd1);
    chk({tag, "_out"}, 64'(bus.ALUOut), 64'(exp));
    chk({tag, "_zero"}, 64'(bus.Zero), 64'(exp == '0));
  endtask

  // Drive one iterative op; wait (bounded) for OutValid and check latency.
  task automatic iter(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp);
    int n;
    @(negedge clk);
    drive(op, a, b);
    n = 0;
    do begin
      @(negedge clk);
      bus.InValid = 1'b0;
      n++;
    end while (!bus.OutValid && n < W + 8);
    chk({tag, "_lat"}, 64'(n), 64'(W + 1));
    chk({tag, "_out"}, 64'(bus.ALUOut), 64'(exp));
  endtask

  logic [3:0]   bop [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011,
                            4'b0100, 4'b0101, 4'b0111, 4'b1111};
  logic [W-1:0] ba  [8] = '{32'd5, 32'd3, 32'hF0F0F0F0, 32'h0F0F0000,
                            32'h0, 32'hAAAAAAAA, 32'h80000000, 32'h12345678};
  logic [W-1:0] bb  [8] = '{32'd3, 32'd5, 32'h0FF00FF0, 32'h000000FF,
                            32'h0, 32'hFFFFFFFF, 32'd31, 32'h9ABCDEF0};
  logic [W-1:0] bx  [8] = '{32'd8, 32'hFFFFFFFE, 32'h00F000F0, 32'h0F0F00FF,
                            32'hFFFFFFFF, 32'h55555555, 32'd1, 32'h0};

  initial begin
    vectors        = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.ALUControl = '0;
    bus.InValid    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out", 64'(bus.ALUOut), 64'd0);
    chk("rst_zero", 64'(bus.Zero), 64'd1);
    chk("rst_vld", 64'(bus.OutValid), 64'd0);
    chk("rst_rdy", 64'(bus.InReady), 64'd1);
    chk("rst_dbz", 64'(bus.DivByZero), 64'd0);
    rst_n = 1'b1;

    // Wrapping add, compares, shift
    single("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0);
    single("slt", 4'b1001, 32'hFFFFFFFF, 32'd1, 32'd1);
    single("sltu", 4'b1000, 32'hFFFFFFFF, 32'd1, 32'd0);
    single("sll", 4'b0110, 32'd1, 32'h25, 32'h20);
    @(negedge clk);
    chk("no_repeat_vld", 64'(bus.OutValid), 64'd0);
    chk("hold_out", 64'(bus.ALUOut), 64'h20);

    // Multiply with cycle-by-cycle ready/valid checks and ignored InValid
    @(negedge clk);
    drive(4'b1010, 32'h00010000, 32'h00010001);
    @(negedge clk);
    bus.InValid = 1'b0;
    chk("mul_rdy0", 64'(bus.InReady), 64'd0);
    chk("mul_vld0", 64'(bus.OutValid), 64'd0);
    for (int i = 1; i < W; i++) begin
      if (i == 5) drive(4'b0000, 32'd1, 32'd1);
      if (i == 8) bus.InValid = 1'b0;
      @(negedge clk);
      chk("mul_rdy_iter", 64'(bus.InReady), 64'd0);
      chk("mul_vld_iter", 64'(bus.OutValid), 64'd0);
    end
    @(negedge clk);
    chk("mul_vld", 64'(bus.OutValid), 64'd1);
    chk("mul_out", 64'(bus.ALUOut), 64'h00010000);
    chk("mul_rdy", 64'(bus.InReady), 64'd1);
    @(negedge clk);
    chk("mul_no_extra", 64'(bus.OutValid), 64'd0);
    chk("mul_hold", 64'(bus.ALUOut), 64'h00010000);

    iter("mul_b", 4'b1010, 32'd12345, 32'd6789, 32'd83810205);

    // Divide / remainder
`ifdef ALU_DIV_EN
    iter("divu", 4'b1011, 32'd100, 32'd7, 32'd14);
    chk("divu_dbz", 64'(bus.DivByZero), 64'd0);
    iter("remu", 4'b1100, 32'd100, 32'd7, 32'd2);
    iter("divu_big", 4'b1011, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF);
    single("divu_z", 4'b1011, 32'd5, 32'd0, 32'hFFFFFFFF);
    chk("divu_z_dbz", 64'(bus.DivByZero), 64'd1);
    single("remu_z", 4'b1100, 32'd9, 32'd0, 32'd9);
    chk("remu_z_dbz", 64'(bus.DivByZero), 64'd1);
    single("add_clr", 4'b0000, 32'd1, 32'd2, 32'd3);
    chk("dbz_clr", 64'(bus.DivByZero), 64'd0);
`else
    single("divu_off", 4'b1011, 32'd100, 32'd7, 32'd0);
    chk("divu_off_rdy", 64'(bus.InReady), 64'd1);
    single("remu_off", 4'b1100, 32'd5, 32'd0, 32'd0);
    chk("div_off_dbz", 64'(bus.DivByZero), 64'd0);
`endif

    // Back-to-back single-cycle ops: OutValid continuous, results in order
    @(negedge clk);
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive(bop[k], ba[k], bb[k]);
      else       bus.InValid = 1'b0;
      if (k > 0) begin
        chk("b2b_vld", 64'(bus.OutValid), 64'd1);
        chk("b2b_out", 64'(bus.ALUOut), 64'(bx[k-1]));
      end
      @(negedge clk);
    end
    chk("b2b_end_vld", 64'(bus.OutValid), 64'd0);

    // Reset in the middle of a multiply
    single("pre_rst", 4'b0000, 32'd7, 32'd1, 32'd8);
    @(negedge clk);
    drive(4'b1010, 32'd3, 32'd5);
    repeat (10) @(negedge clk);
    bus.InValid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_out", 64'(bus.ALUOut), 64'd0);
    chk("mrst_zero", 64'(bus.Zero), 64'd1);
    chk("mrst_vld", 64'(bus.OutValid), 64'd0);
    chk("mrst_rdy", 64'(bus.InReady), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("mrst_no_vld", 64'(bus.OutValid), 64'd0);
    end
    single("post_rst_add", 4'b0000, 32'd2, 32'd3, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
